// File: rtl/sdf_radix2_stage_pkg.sv
// Shared widths, packed-complex field layout and component add/sub helpers
// (wrapping and halving variants) for the SDF radix-2 butterfly stage.
package sdf_radix2_stage_pkg;

  localparam int NB_DEF    = 32;
  localparam int DEPTH_DEF = 8;
  localparam int CW_MAX    = 32;

  // One guard bit above the widest component keeps a+b and a-b exact before scaling.
  typedef logic signed [CW_MAX:0] wide_t;

  function automatic int re_msb(input int nb);
    return nb - 1;
  endfunction

  function automatic int re_lsb(input int nb);
    return nb / 2;
  endfunction

  function automatic int im_msb(input int nb);
    return nb / 2 - 1;
  endfunction

  function automatic wide_t add_wrap(input wide_t a, input wide_t b);
    return a + b;
  endfunction

  function automatic wide_t sub_wrap(input wide_t a, input wide_t b);
    return a - b;
  endfunction

  function automatic wide_t add_half(input wide_t a, input wide_t b);
    return (a + b) >>> 1;
  endfunction

  function automatic wide_t sub_half(input wide_t a, input wide_t b);
    return (a - b) >>> 1;
  endfunction

endpackage

// File: rtl/sdf_radix2_stage_if.sv
// Sample stream into the butterfly (start/in_valid/in_data) and result stream out
// (out_valid/out_data/out_index); master drives samples, slave is the butterfly.
interface sdf_radix2_stage_if
  import sdf_radix2_stage_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int IW = $clog2(2 * DEPTH);

  logic          start;
  logic          in_valid;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic [NB-1:0] out_data;
  logic [IW-1:0] out_index;

  modport master (
    output start, in_valid, in_data,
    input  out_valid, out_data, out_index
  );

  modport slave (
    input  start, in_valid, in_data,
    output out_valid, out_data, out_index
  );

endinterface

// File: rtl/sdf_radix2_stage_cplx_addsub.sv
// Combinational packed-complex a+b / a-b, per component; with BFLY_SCALE_EN the
// results are formed one bit wider and halved (floor), otherwise they wrap.
module sdf_radix2_stage_cplx_addsub
  import sdf_radix2_stage_pkg::*;
#(
  parameter int NB = NB_DEF
) (
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic [NB-1:0] sum,
  output logic [NB-1:0] diff
);

  localparam int CW  = NB / 2;
  localparam int RMS = re_msb(NB);
  localparam int RLS = re_lsb(NB);
  localparam int IMS = im_msb(NB);
  localparam int EXT = CW_MAX + 1 - CW;

  wide_t ar, ai, br, bi;
  wide_t sr, si, dr, di;
  logic  unused_hi;

  always_comb begin
    ar = {{EXT{a[RMS]}}, a[RMS:RLS]};
    ai = {{EXT{a[IMS]}}, a[IMS:0]};
    br = {{EXT{b[RMS]}}, b[RMS:RLS]};
    bi = {{EXT{b[IMS]}}, b[IMS:0]};
`ifdef BFLY_SCALE_EN
    sr = add_half(ar, br);
    si = add_half(ai, bi);
    dr = sub_half(ar, br);
    di = sub_half(ai, bi);
`else
    sr = add_wrap(ar, br);
    si = add_wrap(ai, bi);
    dr = sub_wrap(ar, br);
    di = sub_wrap(ai, bi);
`endif
    sum  = {sr[CW-1:0], si[CW-1:0]};
    diff = {dr[CW-1:0], di[CW-1:0]};
  end

  // Bits above the component width are discarded by design (wrap or post-shift truncation).
  assign unused_hi = ^{sr[CW_MAX:CW], si[CW_MAX:CW], dr[CW_MAX:CW], di[CW_MAX:CW]};

endmodule

// File: rtl/sdf_radix2_stage.sv
// Radix-2 SDF butterfly: 1-cycle latency, no backpressure (in_valid qualifies each sample).
// Build option BFLY_SCALE_EN halves every sum and difference.
module sdf_radix2_stage
  import sdf_radix2_stage_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  sdf_radix2_stage_if.slave  bus
);

  localparam int CNTW = $clog2(2 * DEPTH);
  localparam int KW   = $clog2(DEPTH);

  logic [CNTW-1:0] cnt, cnt_eff;
  logic            pending, pend_eff;
  logic            phase_b;
  logic [KW-1:0]   k;
  logic [NB-1:0]   delay_line [DEPTH];
  logic [NB-1:0]   a_old, bf_sum, bf_diff;
  logic            out_valid_q;
  logic [NB-1:0]   out_data_q;
  logic [CNTW-1:0] out_index_q;

  // A start pulse realigns this very sample to index 0 and drops any undrained differences.
  assign cnt_eff  = bus.start ? '0 : cnt;
  assign pend_eff = bus.start ? 1'b0 : pending;
  assign phase_b  = cnt_eff[CNTW-1];
  assign k        = cnt_eff[KW-1:0];
  assign a_old    = delay_line[k];

  sdf_radix2_stage_cplx_addsub #(.NB(NB)) u_addsub (
    .a    (a_old),
    .b    (bus.in_data),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  // Delay line is data-only storage, never reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      delay_line[k] <= phase_b ? bf_diff : bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pending     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        cnt     <= cnt_eff + 1'b1;
        pending <= pend_eff | (phase_b && (k == KW'(DEPTH - 1)));
        if (phase_b) begin
          out_valid_q <= 1'b1;
          out_data_q  <= bf_sum;
          out_index_q <= {1'b0, k};
        end else if (pend_eff) begin
          out_valid_q <= 1'b1;
          out_data_q  <= a_old;
          out_index_q <= {1'b1, k};
        end
      end else if (bus.start) begin
        cnt     <= '0;
        pending <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

endmodule
